keypad_scanner: RTL and testbench

//   Scans a 4x4 active-low key matrix and reports debounced key presses as 4-bit codes.

---
 rtl/keypad_scanner.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with per-scan debounce and single-cycle press events.
// Optional build macro KEYPAD_HEX_MAP_EN maps matrix positions onto a phone-style hex layout.
//
//   state       | meaning
//   S_IDLE      | no key accepted, waiting for a scan with exactly one key
//   S_PRESS_DEB | same single key seen on consecutive scans, counting toward acceptance
//   S_HELD      | key accepted and reported; further keys ignored until released
//   S_RELEASE_DEB | empty scans seen after a held key, counting toward release
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_ONE   = 2'd1,
      RES_MULTI = 2'd2
   } scan_res_t;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_PRESS_DEB   = 2'd1,
      S_HELD        = 2'd2,
      S_RELEASE_DEB = 2'd3
   } state_t;

   logic [3:0]       r_col_s1;
   logic [3:0]       r_col_s2;
   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_row_idx;
   logic [3:0]       r_row;
   logic [1:0]       r_acc_cnt;
   logic [3:0]       r_acc_k;
   logic             r_scan_done;
   scan_res_t        r_scan_res;
   logic [3:0]       r_scan_k;

   state_t           r_state;
   logic [3:0]       r_cand;
   logic [CNT_W-1:0] r_cnt;
   logic             r_key_valid;
   logic [3:0]       r_key_code;
   logic             r_key_down;

   logic [3:0]       w_low;
   logic [2:0]       w_low_cnt;
   logic [1:0]       w_low_pos;
   logic             w_sample;
   logic [2:0]       w_acc_sum;
   logic [1:0]       w_acc_next;
   logic [3:0]       w_acc_k_next;
   scan_res_t        w_res_next;
   logic [CNT_W-1:0] w_cnt_inc;

   function automatic logic [3:0] f_code(input logic [3:0] k);
`ifdef KEYPAD_HEX_MAP_EN
      logic [3:0] v;
      case (k)
         4'd0:    v = 4'h1;
         4'd1:    v = 4'h2;
         4'd2:    v = 4'h3;
         4'd3:    v = 4'hA;
         4'd4:    v = 4'h4;
         4'd5:    v = 4'h5;
         4'd6:    v = 4'h6;
         4'd7:    v = 4'hB;
         4'd8:    v = 4'h7;
         4'd9:    v = 4'h8;
         4'd10:   v = 4'h9;
         4'd11:   v = 4'hC;
         4'd12:   v = 4'hE;
         4'd13:   v = 4'h0;
         4'd14:   v = 4'hF;
         default: v = 4'hD;
      endcase
      return v;
`else
      return k;
`endif
   endfunction

   assign w_low     = ~r_col_s2;
   assign w_low_cnt = {2'b00, w_low[0]} + {2'b00, w_low[1]} + {2'b00, w_low[2]} + {2'b00, w_low[3]};
   assign w_sample  = (r_div_cnt == DIV_LAST);
   assign w_acc_sum = {1'b0, r_acc_cnt} + w_low_cnt;
   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_low_pos = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_low[i]) w_low_pos = 2'(i);
      end
   end

   // Low-bit tally saturates at two; the key index is only kept if this is the first low bit.
   always_comb begin
      w_acc_next   = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];
      w_acc_k_next = r_acc_k;
      if (r_acc_cnt == 2'd0 && w_low_cnt == 3'd1) w_acc_k_next = {r_row_idx, w_low_pos};
      case (w_acc_next)
         2'd0:    w_res_next = RES_NONE;
         2'd1:    w_res_next = RES_ONE;
         default: w_res_next = RES_MULTI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col_s1    <= 4'hF;
         r_col_s2    <= 4'hF;
         r_div_cnt   <= '0;
         r_row_idx   <= 2'd0;
         r_row       <= 4'b1110;
         r_acc_cnt   <= 2'd0;
         r_acc_k     <= 4'd0;
         r_scan_done <= 1'b0;
         r_scan_res  <= RES_NONE;
         r_scan_k    <= 4'd0;
      end else begin
         r_col_s1    <= col;
         r_col_s2    <= r_col_s1;
         r_scan_done <= 1'b0;
         if (w_sample) begin
            r_div_cnt <= '0;
            r_row_idx <= r_row_idx + 2'd1;
            r_row     <= {r_row[2:0], r_row[3]};
            if (r_row_idx == 2'd3) begin
               r_scan_done <= 1'b1;
               r_scan_res  <= w_res_next;
               r_scan_k    <= w_acc_k_next;
               r_acc_cnt   <= 2'd0;
               r_acc_k     <= 4'd0;
            end else begin
               r_acc_cnt <= w_acc_next;
               r_acc_k   <= w_acc_k_next;
            end
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cand      <= 4'd0;
         r_cnt       <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
         r_key_down  <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (r_scan_done) begin
            case (r_state)
               S_IDLE: begin
                  if (r_scan_res == RES_ONE) begin
                     r_cand <= r_scan_k;
                     if (DEBOUNCE_SCANS == 1) begin
                        r_state     <= S_HELD;
                        r_key_code  <= f_code(r_scan_k);
                        r_key_valid <= 1'b1;
                        r_key_down  <= 1'b1;
                     end else begin
                        r_state <= S_PRESS_DEB;
                        r_cnt   <= CNT_W'(1);
                     end
                  end
               end
               S_PRESS_DEB: begin
                  if (r_scan_res == RES_ONE && r_scan_k == r_cand) begin
                     if (w_cnt_inc == DEB_LAST) begin
                        r_state     <= S_HELD;
                        r_cnt       <= '0;
                        r_key_code  <= f_code(r_cand);
                        r_key_valid <= 1'b1;
                        r_key_down  <= 1'b1;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else if (r_scan_res == RES_ONE) begin
                     r_cand <= r_scan_k;
                     r_cnt  <= CNT_W'(1);
                  end else begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end
               end
               S_HELD: begin
                  if (r_scan_res == RES_NONE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        r_state    <= S_IDLE;
                        r_key_down <= 1'b0;
                     end else begin
                        r_state <= S_RELEASE_DEB;
                        r_cnt   <= CNT_W'(1);
                     end
                  end
               end
               S_RELEASE_DEB: begin
                  if (r_scan_res == RES_NONE) begin
                     if (w_cnt_inc == DEB_LAST) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_key_down <= 1'b0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     // any key activity cancels the release without a new event
                     r_state <= S_HELD;
                     r_cnt   <= '0;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign row       = r_row;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives the columns, expected press
// events are queued with their arrival cycle and matched against key_valid pulses.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] keys;
   logic [15:0] keys1;
   logic [3:0]  col, row, key_code;
   logic        key_valid, key_down;
   logic [3:0]  col1, row1, key_code1;
   logic        key_valid1, key_down1;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .clk(clk), .rst(rst), .col(col), .row(row),
      .key_valid(key_valid), .key_code(key_code), .key_down(key_down)
   );

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(1)) dut1 (
      .clk(clk), .rst(rst), .col(col1), .row(row1),
      .key_valid(key_valid1), .key_code(key_code1), .key_down(key_down1)
   );

   function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] r);
      logic [3:0] c;
      c = 4'hF;
      for (int ri = 0; ri < 4; ri++)
         for (int ci = 0; ci < 4; ci++)
            if (!r[ri] && k[ri*4+ci]) c[ci] = 1'b0;
      return c;
   endfunction

   assign col  = matrix(keys, row);
   assign col1 = matrix(keys1, row1);

   function automatic logic [3:0] exp_code(input int idx);
`ifdef KEYPAD_HEX_MAP_EN
      logic [3:0] m [16];
      m = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
      return m[idx];
`else
      return 4'(idx);
`endif
   endfunction

   typedef struct {
      logic [3:0] code;
      int         at;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   cyc = 0;
   int   n_pulse1 = 0;
   int   p1_base;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (key_valid) begin
            if (sb.size() == 0) begin
               chk_val("spurious_valid", 32'(key_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk_val("valid_code", 32'(key_code), 32'(e.code));
               chk_val("valid_cycle", cyc, e.at);
            end
         end
         if (key_valid1) n_pulse1++;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      keys  = '0;
      keys1 = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      int guard;
      guard = 0;
      while (cyc < t && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != t) chk_val("wait_cyc", cyc, t);
   endtask

   initial begin
      rst   = 1'b1;
      keys  = '0;
      keys1 = '0;

      // reset values and row rotation
      do_reset();
      chk_val("rst_row", 32'(row), 32'b1110);
      chk_val("rst_valid", 32'(key_valid), 32'd0);
      chk_val("rst_down", 32'(key_down), 32'd0);
      chk_val("rst_code", 32'(key_code), 32'd0);
      wait_cyc(3);  chk_val("row_c3", 32'(row), 32'b1110);
      wait_cyc(4);  chk_val("row_c4", 32'(row), 32'b1101);
      chk_val("row1_c4", 32'(row1), 32'b1101);
      wait_cyc(8);  chk_val("row_c8", 32'(row), 32'b1011);
      wait_cyc(12); chk_val("row_c12", 32'(row), 32'b0111);
      wait_cyc(16); chk_val("row_c16", 32'(row), 32'b1110);

      // clean press row2/col1, then release; DEBOUNCE_SCANS=1 instance in parallel
      do_reset();
      p1_base = n_pulse1;
      keys  = 16'h1 << 9;
      keys1 = 16'h1 << 9;
      sb.push_back('{code: exp_code(9), at: 33});
      wait_cyc(16); chk_val("db1_valid_c16", 32'(key_valid1), 32'd0);
      wait_cyc(17);
      chk_val("db1_valid_c17", 32'(key_valid1), 32'd1);
      chk_val("db1_code", 32'(key_code1), 32'(exp_code(9)));
      chk_val("db1_down", 32'(key_down1), 32'd1);
      wait_cyc(18); chk_val("db1_valid_c18", 32'(key_valid1), 32'd0);
      wait_cyc(32); chk_val("press_down_c32", 32'(key_down), 32'd0);
      wait_cyc(33); chk_val("press_down_c33", 32'(key_down), 32'd1);
      wait_cyc(64);
      chk_val("press_down_c64", 32'(key_down), 32'd1);
      chk_val("press_code_c64", 32'(key_code), 32'(exp_code(9)));
      keys  = '0;
      keys1 = '0;
      wait_cyc(96); chk_val("rel_down_c96", 32'(key_down), 32'd1);
      wait_cyc(97);
      chk_val("rel_down_c97", 32'(key_down), 32'd0);
      chk_val("rel_code_hold", 32'(key_code), 32'(exp_code(9)));
      chk_val("db1_rel_down", 32'(key_down1), 32'd0);
      chk_val("db1_pulses", n_pulse1 - p1_base, 32'd1);
      chk_val("press_sb_empty", sb.size(), 32'd0);

      // bounce: key present only on alternate scans
      do_reset();
      for (int s = 0; s < 6; s++) begin
         keys = (s % 2 == 0) ? (16'h1 << 5) : 16'h0;
         wait_cyc(16 * (s + 1));
         chk_val("bounce_down", 32'(key_down), 32'd0);
      end
      keys = '0;
      wait_cyc(112);
      chk_val("bounce_code", 32'(key_code), 32'd0);

      // two keys together from idle
      do_reset();
      keys = (16'h1 << 0) | (16'h1 << 6);
      wait_cyc(80);
      chk_val("multi_down", 32'(key_down), 32'd0);
      chk_val("multi_code", 32'(key_code), 32'd0);

      // rollover: second key while held is ignored
      do_reset();
      keys = 16'h1;
      sb.push_back('{code: exp_code(0), at: 33});
      wait_cyc(48);
      keys = keys | (16'h1 << 15);
      wait_cyc(112);
      chk_val("roll_down", 32'(key_down), 32'd1);
      chk_val("roll_code", 32'(key_code), 32'(exp_code(0)));
      chk_val("roll_sb_empty", sb.size(), 32'd0);

      // brief release then re-press: stays held, no new event
      do_reset();
      keys = 16'h1 << 5;
      sb.push_back('{code: exp_code(5), at: 33});
      wait_cyc(64);
      keys = '0;
      wait_cyc(80);
      keys = 16'h1 << 5;
      wait_cyc(81);  chk_val("glitch_down_c81", 32'(key_down), 32'd1);
      wait_cyc(97);  chk_val("glitch_down_c97", 32'(key_down), 32'd1);
      wait_cyc(128); chk_val("glitch_down_c128", 32'(key_down), 32'd1);
      chk_val("glitch_sb_empty", sb.size(), 32'd0);

      // reset during press debounce
      do_reset();
      keys = 16'h1 << 3;
      wait_cyc(20);
      chk_val("pdeb_down", 32'(key_down), 32'd0);
      rst  = 1'b1;
      keys = '0;
      @(negedge clk);
      chk_val("midrst_row", 32'(row), 32'b1110);
      chk_val("midrst_down", 32'(key_down), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(48);
      chk_val("midrst_down_after", 32'(key_down), 32'd0);
      chk_val("midrst_code_after", 32'(key_code), 32'd0);

      chk_val("final_sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
